cpu_debug_sequencer: RTL

Host-side sequencer for the pipelined CPU's debug ports. Holds the CPU in reset while it streams words into instruction or data memory. Releases the CPU to run until `stop` or a cycle limit, then streams data memory or the 32 registers back out. Sits between the board-level host link (UART/switch bridge) and the CPU's `inst_we`/`data_we`/`rf_dcp_rd` port group.

---
 rtl/cpu_dbg_pkg.sv | 34 +++
 rtl/dbg_rd_stage.sv | 44 ++++
 rtl/cpu_debug_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug sequencer: command opcodes, FSM states
// and memory/RF geometry.
package cpu_dbg_pkg;

  localparam int AW       = 8;
  localparam int RF_WORDS = 32;

  localparam logic [2:0] OP_LOAD_I = 3'd0;
  localparam logic [2:0] OP_LOAD_D = 3'd1;
  localparam logic [2:0] OP_RUN    = 3'd2;
  localparam logic [2:0] OP_DUMP_D = 3'd3;
  localparam logic [2:0] OP_DUMP_R = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_I = 3'd1,
    ST_LOAD_D = 3'd2,
    ST_RUN    = 3'd3,
    ST_DUMP_D = 3'd4,
    ST_DUMP_R = 3'd5
  } state_e;

  function automatic state_e op_to_state(input logic [2:0] op);
    case (op)
      OP_LOAD_I: return ST_LOAD_I;
      OP_LOAD_D: return ST_LOAD_D;
      OP_RUN:    return ST_RUN;
      OP_DUMP_D: return ST_DUMP_D;
      OP_DUMP_R: return ST_DUMP_R;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dbg_rd_stage.sv
// Single-entry registered output stage for the host read stream; holds its
// word stable while the host back-pressures.
module dbg_rd_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              take_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign take_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i && take_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/cpu_debug_sequencer.sv
// Host-side sequencer for the CPU debug ports: loads imem/dmem with the CPU
// held in reset, runs it under a watchdog, and dumps dmem or the RF back out.
module cpu_debug_sequencer #(
  parameter logic [31:0] MAX_CYCLES = 32'd1_000_000,
  parameter int          AW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [31:0]   wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_data,
  output logic          cpu_rstn,
  output logic          inst_we,
  output logic [AW-1:0] inst_addr,
  output logic [31:0]   inst_in,
  output logic          data_we,
  output logic [AW-1:0] data_addr,
  output logic [31:0]   data_in,
  input  logic [31:0]   data_out,
  output logic          rf_dcp_rd,
  output logic [4:0]    rf_addr,
  input  logic [31:0]   rf_out,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          timeout,
  output logic [31:0]   cycle_count
);

  import cpu_dbg_pkg::*;

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, len_q, idx_q, addr;
  logic          issued_q, err_q, timeout_q, done_q;
  logic [31:0]   cyc_q;
  logic          accept, op_legal, last_idx, wr_fire, rd_take, fetch, rd_fire;
  logic          in_dump, run_limit, finish;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign op_legal  = (cmd_op <= OP_DUMP_R);
  assign addr      = base_q + idx_q;
  assign last_idx  = (idx_q == len_q);
  assign wr_fire   = wr_valid && wr_ready;
  assign in_dump   = (state_q == ST_DUMP_D) || (state_q == ST_DUMP_R);
  assign fetch     = in_dump && !issued_q && rd_take;
  assign rd_fire   = rd_valid && rd_ready;
  assign run_limit = (cyc_q == MAX_CYCLES - 32'd1);
  assign finish    = (state_q != ST_IDLE) && (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept && op_legal) state_d = op_to_state(cmd_op);
      ST_LOAD_I,
      ST_LOAD_D: if (wr_fire && last_idx) state_d = ST_IDLE;
      ST_RUN:    if (stop || run_limit) state_d = ST_IDLE;
      ST_DUMP_D,
      ST_DUMP_R: if (issued_q && rd_fire) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    wr_ready  = (state_q == ST_LOAD_I) || (state_q == ST_LOAD_D);
    inst_we   = (state_q == ST_LOAD_I) && wr_valid;
    data_we   = (state_q == ST_LOAD_D) && wr_valid;
    rf_dcp_rd = (state_q == ST_DUMP_R);
    cpu_rstn  = (state_q == ST_RUN);
  end

  assign inst_addr   = addr;
  assign inst_in     = wr_data;
  assign data_addr   = addr;
  assign data_in     = wr_data;
  assign rf_addr     = idx_q[4:0];
  assign done        = done_q;
  assign err         = err_q;
  assign timeout     = timeout_q;
  assign cycle_count = cyc_q;

  // A timeout is only flagged when stop is not seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      issued_q  <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      cyc_q     <= '0;
    end else begin
      done_q <= finish || (accept && !op_legal);
      if (accept) begin
        base_q    <= cmd_base;
        len_q     <= (cmd_op == OP_DUMP_R) ? AW'(RF_WORDS - 1) : cmd_len;
        idx_q     <= '0;
        issued_q  <= 1'b0;
        err_q     <= !op_legal;
        timeout_q <= 1'b0;
        if (cmd_op == OP_RUN) cyc_q <= '0;
      end else begin
        if (wr_fire || fetch) idx_q <= idx_q + AW'(1);
        if (fetch && last_idx) issued_q <= 1'b1;
        if (state_q == ST_RUN) begin
          cyc_q <= cyc_q + 32'd1;
          if (!stop && run_limit) timeout_q <= 1'b1;
        end
      end
    end
  end

  dbg_rd_stage #(.DATA_W(32)) u_rd_stage (
    .clk     (clk),
    .rst     (rst),
    .load_i  (fetch),
    .data_i  ((state_q == ST_DUMP_R) ? rf_out : data_out),
    .take_o  (rd_take),
    .valid_o (rd_valid),
    .data_o  (rd_data),
    .ready_i (rd_ready)
  );

endmodule
